// File: rtl/vm_pkg.sv
// vm_pkg: definitions shared by the vending machine money paths.
// Holds the coin code enum, the cent value of each code, the amount
// limits, and the change dispenser state encoding.
package vm_pkg;

  localparam int AMT_W     = 9;
  localparam int MAX_CENTS = 500;

  localparam int NICKEL_CENTS  = 5;
  localparam int DIME_CENTS    = 10;
  localparam int QUARTER_CENTS = 25;
  localparam int DOLLAR_CENTS  = 100;

  // Code order matches the tube_empty bit order, smallest value first.
  typedef enum logic [1:0] {
    NICKEL  = 2'b00,
    DIME    = 2'b01,
    QUARTER = 2'b10,
    DOLLAR  = 2'b11
  } coin_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SELECT = 2'b01,
    ST_ISSUE  = 2'b10,
    ST_DONE   = 2'b11
  } disp_state_e;

  function automatic int unsigned coin_cents(input coin_e c);
    case (c)
      NICKEL:  return NICKEL_CENTS;
      DIME:    return DIME_CENTS;
      QUARTER: return QUARTER_CENTS;
      default: return DOLLAR_CENTS;
    endcase
  endfunction

endpackage

// File: rtl/change_coin_picker.sv
// change_coin_picker: combinational largest-coin-first selection.
// Ports:
//   remaining  - cents still owed
//   tube_empty - per-code empty flags, bit index = coin code
//   found      - a coin that fits and is available exists
//   code       - coin code of the largest such coin (NICKEL when !found)
module change_coin_picker #(
  parameter int AMT_W = 9
) (
  input  logic [AMT_W-1:0] remaining,
  input  logic [3:0]       tube_empty,
  output logic             found,
  output logic [1:0]       code
);
  import vm_pkg::*;

  localparam logic [AMT_W-1:0] V_NICKEL  = AMT_W'(NICKEL_CENTS);
  localparam logic [AMT_W-1:0] V_DIME    = AMT_W'(DIME_CENTS);
  localparam logic [AMT_W-1:0] V_QUARTER = AMT_W'(QUARTER_CENTS);
  localparam logic [AMT_W-1:0] V_DOLLAR  = AMT_W'(DOLLAR_CENTS);

  always_comb begin
    found = 1'b1;
    code  = NICKEL;
    // Priority order is the denomination order, largest first.
    if (!tube_empty[DOLLAR] && remaining >= V_DOLLAR) begin
      code = DOLLAR;
    end else if (!tube_empty[QUARTER] && remaining >= V_QUARTER) begin
      code = QUARTER;
    end else if (!tube_empty[DIME] && remaining >= V_DIME) begin
      code = DIME;
    end else if (!tube_empty[NICKEL] && remaining >= V_NICKEL) begin
      code = NICKEL;
    end else begin
      found = 1'b0;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out a cent amount as a sequence of coin ejects.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start, amount   - payout request, amount latched when accepted in IDLE
//   tube_empty      - per-code empty flags, sampled in SELECT
//   eject_ready     - coin mechanism accepts the pending coin this cycle
//   coin_valid      - eject request pending; coin_sel is its coin code
//   busy, done      - not IDLE; one-cycle end-of-payout pulse
//   err, short      - last request rejected; last payout ran out of coins
//   remaining       - cents still owed (unpaid balance after short)
//   fsm_state       - current state, for observation
// Handshake: a coin transfers on a rising edge where coin_valid and
// eject_ready are both high; coin_valid/coin_sel stay put until then.
module change_dispenser #(
  parameter int MAX_CENTS = vm_pkg::MAX_CENTS,
  parameter int AMT_W     = vm_pkg::AMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic [3:0]       tube_empty,
  input  logic             eject_ready,
  output logic             coin_valid,
  output logic [1:0]       coin_sel,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             short,
  output logic [AMT_W-1:0] remaining,
  output logic [1:0]       fsm_state
);
  import vm_pkg::*;

  disp_state_e      state;
  logic             pick_found;
  logic [1:0]       pick_code;
  logic             amount_ok;
  logic [AMT_W-1:0] sel_cents;

  // Valid amounts are whole nickels no larger than the limit.
  assign amount_ok = ((amount % AMT_W'(NICKEL_CENTS)) == '0) &&
                     (amount <= AMT_W'(MAX_CENTS));
  assign sel_cents = AMT_W'(coin_cents(coin_e'(coin_sel)));
  assign fsm_state = state;

  change_coin_picker #(.AMT_W(AMT_W)) u_picker (
    .remaining  (remaining),
    .tube_empty (tube_empty),
    .found      (pick_found),
    .code       (pick_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      coin_valid <= 1'b0;
      coin_sel   <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      short      <= 1'b0;
      remaining  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            short <= 1'b0;
            if (amount_ok) begin
              remaining <= amount;
              err       <= 1'b0;
              state     <= ST_SELECT;
            end else begin
              remaining <= '0;
              err       <= 1'b1;
              done      <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        ST_SELECT: begin
          if (remaining == '0) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (pick_found) begin
            coin_sel   <= pick_code;
            coin_valid <= 1'b1;
            state      <= ST_ISSUE;
          end else begin
            // Balance cannot be made from the stocked tubes.
            short <= 1'b1;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_ISSUE: begin
          if (eject_ready) begin
            // The picker only offers coins <= remaining, so no underflow.
            remaining  <= remaining - sel_cents;
            coin_valid <= 1'b0;
            state      <= ST_SELECT;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: scoreboard bench for change_dispenser. Requests are
// turned into expected coin codes and end results by a greedy payout model;
// a negedge monitor pops and compares on every transfer and every done.
module tb_change_dispenser;
  import vm_pkg::*;

  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst, start, eject_ready;
  logic [W-1:0] amount;
  logic [3:0]   tube_empty;
  logic         coin_valid, busy, done, err, short;
  logic [1:0]   coin_sel, fsm_state;
  logic [W-1:0] remaining;

  change_dispenser dut (
    .clk (clk), .rst (rst), .start (start), .amount (amount),
    .tube_empty (tube_empty), .eject_ready (eject_ready),
    .coin_valid (coin_valid), .coin_sel (coin_sel), .busy (busy),
    .done (done), .err (err), .short (short), .remaining (remaining),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int xfer_cnt = 0;
  logic [1:0]  exp_q[$];      // expected coin codes in eject order
  logic [10:0] end_q[$];      // expected {err, short, remaining} at done
  logic [10:0] last_end = '0;
  logic        prev_stall = 1'b0;
  logic [1:0]  prev_sel = '0;
  logic [10:0] e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Greedy payout from the rules: largest stocked coin that fits.
  task automatic expect_payout(input int amt, input logic [3:0] te, output int ncoins);
    int vals[4];
    int rem, pick;
    bit sh;
    vals = '{5, 10, 25, 100};
    ncoins = 0;
    if (amt % 5 != 0 || amt > 500) begin
      last_end = {1'b1, 1'b0, 9'd0};
      end_q.push_back(last_end);
      return;
    end
    rem = amt;
    sh = 0;
    while (rem > 0) begin
      pick = -1;
      for (int d = 3; d >= 0; d--)
        if (pick < 0 && !te[d] && vals[d] <= rem) pick = d;
      if (pick < 0) begin
        sh = 1;
        break;
      end
      exp_q.push_back(2'(pick));
      rem -= vals[pick];
      ncoins++;
    end
    last_end = {1'b0, sh, 9'(rem)};
    end_q.push_back(last_end);
  endtask

  // Monitor: transfers, stall holding, and end-of-payout results.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        check("hold_valid", 32'(coin_valid), 1);
        check("hold_sel", 32'(coin_sel), 32'(prev_sel));
      end
      if (coin_valid && eject_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_coin: got %0d expected none", coin_sel);
        end else begin
          check("coin_sel", 32'(coin_sel), 32'(exp_q.pop_front()));
        end
        xfer_cnt++;
      end
      if (done) begin
        check("done_busy", 32'(busy), 1);
        if (end_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got 1 expected 0");
        end else begin
          e = end_q.pop_front();
          check("end_err", 32'(err), 32'(e[10]));
          check("end_short", 32'(short), 32'(e[9]));
          check("end_remaining", 32'(remaining), 32'(e[8:0]));
        end
      end
      prev_stall = coin_valid && !eject_ready;
      prev_sel = coin_sel;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    eject_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // mode 0: eject_ready always high, 1: random, 2: 3-cycle stall on 2nd coin.
  task automatic run(input int amt, input logic [3:0] te, input int mode, input bit poke);
    int base, stall_left, lat, nexp, exp_lat;
    expect_payout(amt, te, nexp);
    exp_lat = (amt % 5 != 0 || amt > 500) ? 0 : 2 * nexp + 1;
    tube_empty = te;
    amount = W'(amt);
    start = 1'b1;
    base = xfer_cnt;
    stall_left = 3;
    tick();
    start = 1'b0;
    lat = -1;
    for (int c = 0; c < 2000; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      case (mode)
        0: eject_ready = 1'b1;
        1: eject_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (coin_valid && (xfer_cnt - base) == 1 && stall_left > 0) begin
            eject_ready = 1'b0;
            stall_left--;
          end else begin
            eject_ready = 1'b1;
          end
        end
      endcase
      // A request while busy must be dropped.
      if (poke && c == 3) begin
        start = 1'b1;
        amount = W'(45);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    if (lat < 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got none expected done for amount %0d", amt);
      do_reset();
      exp_q.delete();
      end_q.delete();
      return;
    end
    if (mode == 0) check("done_latency", 32'(lat), 32'(exp_lat));
    check("xfer_count", 32'(xfer_cnt - base), 32'(nexp));
    tick();
    check("idle_busy", 32'(busy), 0);
    check("idle_done", 32'(done), 0);
    check("hold_err", 32'(err), 32'(last_end[10]));
    check("hold_short", 32'(short), 32'(last_end[9]));
    check("hold_remaining", 32'(remaining), 32'(last_end[8:0]));
  endtask

  initial begin
    int base, n, amt;
    rst = 1'b1;
    start = 1'b0;
    eject_ready = 1'b0;
    amount = '0;
    tube_empty = 4'b0000;
    do_reset();

    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    check("rst_coin_valid", 32'(coin_valid), 0);
    check("rst_coin_sel", 32'(coin_sel), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_short", 32'(short), 0);
    check("rst_remaining", 32'(remaining), 0);

    run(190, 4'b0000, 0, 0);
    run(100, 4'b1000, 2, 0);
    run(15, 4'b0011, 0, 0);
    run(7, 4'b0000, 0, 0);
    run(505, 4'b0000, 0, 0);
    run(20, 4'b0000, 0, 0);
    run(60, 4'b0000, 0, 1);
    run(0, 4'b0000, 0, 0);
    run(500, 4'b0000, 0, 0);
    run(495, 4'b0000, 1, 0);

    // Reset after the 2nd of five dollar coins.
    expect_payout(500, 4'b0000, n);
    tube_empty = 4'b0000;
    amount = W'(500);
    start = 1'b1;
    base = xfer_cnt;
    tick();
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (xfer_cnt - base >= 2) break;
      eject_ready = 1'b1;
      tick();
    end
    check("pre_rst_xfers", 32'(xfer_cnt - base), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_state", 32'(fsm_state), 32'(ST_IDLE));
    check("mid_rst_remaining", 32'(remaining), 0);
    check("mid_rst_coin_valid", 32'(coin_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    exp_q.delete();
    end_q.delete();
    for (int c = 0; c < 10; c++) tick();
    check("post_rst_xfers", 32'(xfer_cnt - base), 2);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 9) == 0) amt = int'($urandom_range(0, 511));
      else amt = 5 * int'($urandom_range(0, 100));
      run(amt, 4'($urandom_range(0, 15)), int'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    tick();
    check("coins_left", 32'(exp_q.size()), 0);
    check("ends_left", 32'(end_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
